can_stuff_ctrl: RTL and testbench

Bit-level stuffing controller between the CAN frame builder/parser and the bit-timing unit. On transmit, it pulls frame bits from upstream one per bit tick and inserts a complementary stuff bit after five identical bits, stalling upstream for that tick. On receive, it removes stuff bits, flags stuff errors, and forwards data bits upstream. Stuffing is confined to the SOF..CRC-sequence window signalled by upstream.

---
 rtl/can_stuff_ctrl_pkg.sv | 16 +
 rtl/can_stuff_ctrl_run_counter.sv | 46 ++++
 rtl/can_stuff_ctrl.sv | 159 +++++++++++++++
 tb/tb_can_stuff_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/can_stuff_ctrl_pkg.sv
// Shared definitions for the CAN bit-stuffing controller: FSM states, run
// length and bus level constants.
package can_defs;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      STUFF = 2'd1,
      FIXED = 2'd2
   } stuff_state_e;

   localparam int   STUFF_RUN     = 5;
   localparam int   RUN_W         = 3;
   localparam logic CAN_RECESSIVE = 1'b1;
   localparam logic CAN_DOMINANT  = 1'b0;

endpackage

// File: rtl/can_stuff_ctrl_run_counter.sv
// Identical-bit run tracker shared by the tx and rx paths. Holds the last bus
// bit and the length of the current run, saturating at the stuff position.
module can_run_counter
   import can_defs::*;
#(
   parameter int RUN = STUFF_RUN
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clr,
   input  logic i_load,
   input  logic i_adv,
   input  logic i_bit,
   output logic o_prev_bit,
   output logic o_at_stuff_pos
);

   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(RUN);
   localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

   logic [RUN_W-1:0] r_run_cnt;
   logic             r_prev_bit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_run_cnt  <= '0;
         r_prev_bit <= CAN_RECESSIVE;
      end else if (i_clr) begin
         r_run_cnt  <= '0;
         r_prev_bit <= CAN_RECESSIVE;
      end else if (i_load) begin
         r_run_cnt  <= RUN_ONE;
         r_prev_bit <= i_bit;
      end else if (i_adv) begin
         if (i_bit != r_prev_bit)
            r_run_cnt <= RUN_ONE;
         else if (r_run_cnt < RUN_MAX)
            r_run_cnt <= r_run_cnt + RUN_ONE;
         r_prev_bit <= i_bit;
      end
   end

   assign o_prev_bit     = r_prev_bit;
   assign o_at_stuff_pos = (r_run_cnt == RUN_MAX);

endmodule

// File: rtl/can_stuff_ctrl.sv
// CAN bit-stuffing controller: inserts stuff bits on transmit, removes and
// checks them on receive, within the SOF..CRC window flagged by upstream.
//
// state | meaning
// IDLE  | no frame; bus recessive, waiting for bit_tick & frame_start
// STUFF | stuffed region; stuff bit forced after RUN_LEN identical bits
// FIXED | unstuffed tail of frame until frame_end
module can_stuff_ctrl
   import can_defs::*;
#(
   parameter int RUN_LEN = STUFF_RUN
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_bit_tick,
   input  logic i_mode_tx,
   input  logic i_frame_start,
   input  logic i_stuff_en,
   input  logic i_frame_end,
   input  logic i_abort,
   input  logic i_tx_bit,
   output logic o_tx_take,
   output logic o_can_tx,
   input  logic i_can_rx,
   output logic o_rx_bit,
   output logic o_rx_valid,
   output logic o_stuff_err,
   output logic o_stuff_active,
   output logic o_busy
);

   stuff_state_e r_state, w_state_nxt;
   logic r_mode_tx, w_mode_nxt;
   logic r_can_tx, w_can_tx_nxt;
   logic r_rx_bit, w_rx_bit_nxt;
   logic r_rx_valid, w_rx_valid_nxt;
   logic r_stuff_err, w_stuff_err_nxt;
   logic w_take;
   logic w_cnt_load, w_cnt_adv, w_cnt_bit;
   logic w_prev_bit, w_at_stuff_pos;

   can_run_counter #(.RUN(RUN_LEN)) u_run_cnt (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_clr          (i_abort),
      .i_load         (w_cnt_load),
      .i_adv          (w_cnt_adv),
      .i_bit          (w_cnt_bit),
      .o_prev_bit     (w_prev_bit),
      .o_at_stuff_pos (w_at_stuff_pos)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_mode_tx   <= 1'b0;
         r_can_tx    <= CAN_RECESSIVE;
         r_rx_bit    <= CAN_RECESSIVE;
         r_rx_valid  <= 1'b0;
         r_stuff_err <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_mode_tx   <= w_mode_nxt;
         r_can_tx    <= w_can_tx_nxt;
         r_rx_bit    <= w_rx_bit_nxt;
         r_rx_valid  <= w_rx_valid_nxt;
         r_stuff_err <= w_stuff_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_mode_nxt      = r_mode_tx;
      w_can_tx_nxt    = r_can_tx;
      w_rx_bit_nxt    = r_rx_bit;
      w_rx_valid_nxt  = 1'b0;
      w_stuff_err_nxt = 1'b0;
      w_take          = 1'b0;
      w_cnt_load      = 1'b0;
      w_cnt_adv       = 1'b0;
      w_cnt_bit       = r_mode_tx ? i_tx_bit : i_can_rx;

      if (i_abort) begin
         w_state_nxt  = IDLE;
         w_can_tx_nxt = CAN_RECESSIVE;
      end else if (i_bit_tick) begin
         case (r_state)
            IDLE: begin
               w_can_tx_nxt = CAN_RECESSIVE;
               if (i_frame_start) begin
                  w_mode_nxt  = i_mode_tx;
                  w_state_nxt = STUFF;
                  w_cnt_load  = 1'b1;
                  w_cnt_bit   = i_mode_tx ? i_tx_bit : i_can_rx;
                  if (i_mode_tx) begin
                     w_take       = 1'b1;
                     w_can_tx_nxt = i_tx_bit;
                  end else begin
                     w_rx_bit_nxt   = i_can_rx;
                     w_rx_valid_nxt = 1'b1;
                  end
               end
            end
            STUFF: begin
               if (w_at_stuff_pos) begin
                  // Stuff bit starts the next run; a pending one is still
                  // handled even when the stuffed region has just closed.
                  w_cnt_load = 1'b1;
                  w_cnt_bit  = ~w_prev_bit;
                  if (r_mode_tx)
                     w_can_tx_nxt = ~w_prev_bit;
                  if (!r_mode_tx && (i_can_rx == w_prev_bit)) begin
                     w_stuff_err_nxt = 1'b1;
                     w_state_nxt     = IDLE;
                  end else if (i_frame_end)
                     w_state_nxt = IDLE;
                  else if (!i_stuff_en)
                     w_state_nxt = FIXED;
               end else begin
                  if (r_mode_tx) begin
                     w_take       = 1'b1;
                     w_can_tx_nxt = i_tx_bit;
                  end else begin
                     w_rx_bit_nxt   = i_can_rx;
                     w_rx_valid_nxt = 1'b1;
                  end
                  if (i_frame_end)
                     w_state_nxt = IDLE;
                  else if (!i_stuff_en)
                     w_state_nxt = FIXED;
                  else
                     w_cnt_adv = 1'b1;
               end
            end
            FIXED: begin
               if (r_mode_tx) begin
                  w_take       = 1'b1;
                  w_can_tx_nxt = i_tx_bit;
               end else begin
                  w_rx_bit_nxt   = i_can_rx;
                  w_rx_valid_nxt = 1'b1;
               end
               if (i_frame_end)
                  w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   assign o_tx_take      = w_take;
   assign o_can_tx       = r_can_tx;
   assign o_rx_bit       = r_rx_bit;
   assign o_rx_valid     = r_rx_valid;
   assign o_stuff_err    = r_stuff_err;
   assign o_stuff_active = (r_state == STUFF);
   assign o_busy         = (r_state != IDLE);

endmodule

// File: tb/tb_can_stuff_ctrl.sv
// Directed bench for can_stuff_ctrl: each bit tick pushes its hand-computed
// response; a monitor pops and compares one clock after the tick.
module tb_can_stuff_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic bit_tick = 1'b0, mode_tx = 1'b0, frame_start = 1'b0, stuff_en = 1'b0;
   logic frame_end = 1'b0, abort = 1'b0, tx_bit = 1'b1, can_rx = 1'b1;
   logic tx_take, can_tx, rx_bit, rx_valid, stuff_err, stuff_active, busy;

   typedef struct packed {
      logic take, ctx, rv, rb, err, busy, act;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   logic pend = 1'b0;
   logic take_cap = 1'b0;

   always #5 clk = ~clk;

   can_stuff_ctrl dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_bit_tick     (bit_tick),
      .i_mode_tx      (mode_tx),
      .i_frame_start  (frame_start),
      .i_stuff_en     (stuff_en),
      .i_frame_end    (frame_end),
      .i_abort        (abort),
      .i_tx_bit       (tx_bit),
      .o_tx_take      (tx_take),
      .o_can_tx       (can_tx),
      .i_can_rx       (can_rx),
      .o_rx_bit       (rx_bit),
      .o_rx_valid     (rx_valid),
      .o_stuff_err    (stuff_err),
      .o_stuff_active (stuff_active),
      .o_busy         (busy)
   );

   task automatic chk(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         pend <= 1'b0;
      end else begin
         if (pend) begin
            if (q.size() == 0) begin
               chk("scoreboard_empty", 1'b1, 1'b0);
            end else begin
               e = q.pop_front();
               chk("tx_take", take_cap, e.take);
               chk("can_tx", can_tx, e.ctx);
               chk("rx_valid", rx_valid, e.rv);
               if (e.rv) chk("rx_bit", rx_bit, e.rb);
               chk("stuff_err", stuff_err, e.err);
               chk("busy", busy, e.busy);
               chk("stuff_active", stuff_active, e.act);
            end
         end
         pend     <= bit_tick;
         take_cap <= tx_take;
      end
   end

   // One bit time: inputs for the tick followed by the expected response.
   task automatic tk(input logic ab, fs, se, fe, txb, rxb,
                     input logic e_take, e_ctx, e_rv, e_rb, e_err, e_busy, e_act);
      exp_t e;
      e = '{take: e_take, ctx: e_ctx, rv: e_rv, rb: e_rb, err: e_err,
            busy: e_busy, act: e_act};
      q.push_back(e);
      @(posedge clk); #1;
      abort = ab; frame_start = fs; stuff_en = se; frame_end = fe;
      tx_bit = txb; can_rx = rxb; bit_tick = 1'b1;
      @(posedge clk); #1;
      bit_tick = 1'b0; abort = 1'b0; frame_start = 1'b0; frame_end = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_can_tx"}, can_tx, 1'b1);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_active"}, stuff_active, 1'b0);
      chk({tag, "_rx_valid"}, rx_valid, 1'b0);
      chk({tag, "_stuff_err"}, stuff_err, 1'b0);
      chk({tag, "_rx_bit"}, rx_bit, 1'b1);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_idle_outputs("reset");
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // TX: five zeros -> stuff 1; then four data 1s -> stuff 0
      mode_tx = 1'b1;
      //  ab fs se fe tx rx | take ctx rv rb err busy act
      tk(0, 1, 1, 0, 0, 1,   1, 0, 0, 0, 0, 1, 1);
      for (int i = 0; i < 4; i++)
         tk(0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 1, 1);
      tk(0, 0, 1, 0, 1, 1,   0, 1, 0, 0, 0, 1, 1);
      for (int i = 0; i < 4; i++)
         tk(0, 0, 1, 0, 1, 1, 1, 1, 0, 0, 0, 1, 1);
      tk(0, 0, 1, 0, 1, 1,   0, 0, 0, 0, 0, 1, 1);
      tk(0, 0, 1, 0, 1, 1,   1, 1, 0, 0, 0, 1, 1);
      tk(0, 0, 0, 1, 0, 1,   1, 0, 0, 0, 0, 0, 0);
      tk(0, 0, 0, 0, 0, 1,   0, 1, 0, 0, 0, 0, 0);

      // RX: six zeros -> five data bits then stuff error
      mode_tx = 1'b0;
      tk(0, 1, 1, 0, 1, 0,   0, 1, 1, 0, 0, 1, 1);
      for (int i = 0; i < 4; i++)
         tk(0, 0, 1, 0, 1, 0, 0, 1, 1, 0, 0, 1, 1);
      tk(0, 0, 1, 0, 1, 0,   0, 1, 0, 0, 1, 0, 0);

      // RX: five ones then stuff 0 removed, following bits forwarded
      tk(0, 1, 1, 0, 1, 1,   0, 1, 1, 1, 0, 1, 1);
      for (int i = 0; i < 4; i++)
         tk(0, 0, 1, 0, 1, 1, 0, 1, 1, 1, 0, 1, 1);
      tk(0, 0, 1, 0, 1, 0,   0, 1, 0, 0, 0, 1, 1);
      tk(0, 0, 1, 0, 1, 1,   0, 1, 1, 1, 0, 1, 1);
      tk(0, 0, 1, 0, 1, 0,   0, 1, 1, 0, 0, 1, 1);
      tk(0, 0, 1, 1, 1, 1,   0, 1, 1, 1, 0, 0, 0);

      // TX region end: pending stuff after last CRC bit, then 11 recessive
      mode_tx = 1'b1;
      tk(0, 1, 1, 0, 0, 1,   1, 0, 0, 0, 0, 1, 1);
      for (int i = 0; i < 5; i++)
         tk(0, 0, 1, 0, 1, 1, 1, 1, 0, 0, 0, 1, 1);
      tk(0, 0, 0, 0, 1, 1,   0, 0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 10; i++)
         tk(0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 1, 0);
      tk(0, 0, 0, 1, 1, 1,   1, 1, 0, 0, 0, 0, 0);
      tk(0, 0, 0, 0, 1, 1,   0, 1, 0, 0, 0, 0, 0);

      // Abort mid-STUFF, then frame_start without a tick is ignored
      tk(0, 1, 1, 0, 0, 1,   1, 0, 0, 0, 0, 1, 1);
      tk(0, 0, 1, 0, 0, 1,   1, 0, 0, 0, 0, 1, 1);
      tk(1, 0, 1, 0, 0, 1,   0, 1, 0, 0, 0, 0, 0);
      @(posedge clk); #1 frame_start = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("fs_no_tick_busy", busy, 1'b0);
      end
      @(posedge clk); #1 frame_start = 1'b0;
      repeat (2) @(posedge clk);

      // Reset mid-STUFF returns outputs to reset values immediately
      tk(0, 1, 1, 0, 0, 1,   1, 0, 0, 0, 0, 1, 1);
      tk(0, 0, 1, 0, 0, 1,   1, 0, 0, 0, 0, 1, 1);
      @(negedge clk); rst_n = 1'b0;
      #1 chk_idle_outputs("mid_reset");
      @(negedge clk); rst_n = 1'b1;
      tk(0, 0, 1, 0, 0, 1,   0, 1, 0, 0, 0, 0, 0);

      repeat (5) @(posedge clk);
      chk("scoreboard_drained", (q.size() == 0), 1'b1);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
